// File: rtl/book_side_levels_pkg.sv
// Shared book types: one aggregated price level, update opcode, side constants
// and the update-sequencer state encoding.
package book_side_levels_pkg;

  localparam int BOOK_PRICE_W  = 32;
  localparam int BOOK_SHARES_W = 32;

  localparam bit SIDE_BUY  = 1'b0;
  localparam bit SIDE_SELL = 1'b1;

  typedef enum logic {
    BOOK_ADD    = 1'b0,
    BOOK_REDUCE = 1'b1
  } bookOpType;

  typedef struct packed {
    logic [BOOK_PRICE_W-1:0]  price;
    logic [BOOK_SHARES_W-1:0] shares;
  } bookLevelType;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_APPLY = 1'b1
  } bookStateType;

endpackage

// File: rtl/book_side_levels_cmp.sv
// Per-level comparator: does the request hit this level exactly, and would a
// new level at the request price sort ahead of it. Empty levels lose to any price.
module book_level_cmp
  import book_side_levels_pkg::*;
#(
  parameter bit SIDE    = SIDE_BUY,
  parameter int PRICE_W = BOOK_PRICE_W
) (
  input  logic               levValid,
  input  logic [PRICE_W-1:0] levPrice,
  input  logic [PRICE_W-1:0] reqPrice,
  output logic               match,
  output logic               better,
  output logic               valid
);

  // Exact-match and ordering decision for one level
  always_comb begin
    valid = levValid;
    match = levValid && (reqPrice == levPrice);
    if (!levValid) begin
      better = 1'b1;
    end else if (SIDE == SIDE_BUY) begin
      better = (reqPrice > levPrice);
    end else begin
      better = (reqPrice < levPrice);
    end
  end

endmodule

// File: rtl/book_side_levels.sv
// Sorted, aggregated price-level book for one side of one instrument.
// An accepted update is registered, applied in a single APPLY cycle against
// all levels in parallel, and the top-of-book outputs follow one cycle later.
module book_side_levels
  import book_side_levels_pkg::*;
#(
  parameter int DEPTH    = 5,
  parameter bit SIDE     = SIDE_BUY,
  parameter int PRICE_W  = BOOK_PRICE_W,
  parameter int SHARES_W = BOOK_SHARES_W,
  localparam int CNT_W   = $clog2(DEPTH + 1)
) (
  input  logic                clkIn,
  input  logic                rstIn,
  input  logic                updValidIn,
  output logic                updReadyOut,
  input  bookOpType           updOpIn,
  input  logic [PRICE_W-1:0]  updPriceIn,
  input  logic [SHARES_W-1:0] updSharesIn,
  output bookLevelType        topLevelOut,
  output logic                topValidOut,
  output logic [CNT_W-1:0]    levelCntOut,
  output logic                topChgOut,
  output logic                offBookOut,
  output logic                missOut
);

  localparam int IDX_W = $clog2(DEPTH);

  // Share aggregation clamps at all-ones instead of wrapping
  function automatic logic [SHARES_W-1:0] satAdd(input logic [SHARES_W-1:0] a,
                                                 input logic [SHARES_W-1:0] b);
    logic [SHARES_W:0] sum;
    sum = {1'b0, a} + {1'b0, b};
    if (sum[SHARES_W]) begin
      return {SHARES_W{1'b1}};
    end else begin
      return sum[SHARES_W-1:0];
    end
  endfunction

  bookStateType        state, stateNext;
  logic                accept;
  bookOpType           reqOp;
  logic [PRICE_W-1:0]  reqPrice;
  logic [SHARES_W-1:0] reqShares;

  logic [DEPTH-1:0]    levValid, levValidNext;
  logic [PRICE_W-1:0]  levPrice      [DEPTH];
  logic [PRICE_W-1:0]  levPriceNext  [DEPTH];
  logic [SHARES_W-1:0] levShares     [DEPTH];
  logic [SHARES_W-1:0] levSharesNext [DEPTH];
  logic                offPend, offNext, missPend, missNext;

  logic [DEPTH-1:0]    cmpMatch, cmpBetter, cmpValid;
  logic [IDX_W-1:0]    matchIdx, insIdx;
  logic                anyMatch, anyIns;
  logic [CNT_W-1:0]    validCount;

  assign accept = updValidIn && updReadyOut;

  for (genvar g = 0; g < DEPTH; g++) begin : gCmp
    book_level_cmp #(.SIDE(SIDE), .PRICE_W(PRICE_W)) uCmp (
      .levValid (levValid[g]),
      .levPrice (levPrice[g]),
      .reqPrice (reqPrice),
      .match    (cmpMatch[g]),
      .better   (cmpBetter[g]),
      .valid    (cmpValid[g])
    );
  end

  // Sequencer state register
  always_ff @(posedge clkIn) begin
    if (rstIn) begin
      state <= ST_IDLE;
    end else begin
      state <= stateNext;
    end
  end

  // Next state: one APPLY cycle per accepted update
  always_comb begin
    stateNext = state;
    case (state)
      ST_IDLE: begin
        if (accept) begin
          stateNext = ST_APPLY;
        end else begin
          stateNext = ST_IDLE;
        end
      end
      ST_APPLY: stateNext = ST_IDLE;
      default:  stateNext = ST_IDLE;
    endcase
  end

  // Ready flag and request capture; ready drops only for the APPLY cycle
  always_ff @(posedge clkIn) begin
    if (rstIn) begin
      updReadyOut <= 1'b0;
      reqOp       <= BOOK_ADD;
      reqPrice    <= {PRICE_W{1'b0}};
      reqShares   <= {SHARES_W{1'b0}};
    end else begin
      updReadyOut <= (stateNext == ST_IDLE);
      if (accept) begin
        reqOp     <= updOpIn;
        reqPrice  <= updPriceIn;
        reqShares <= updSharesIn;
      end else begin
        reqOp     <= reqOp;
        reqPrice  <= reqPrice;
        reqShares <= reqShares;
      end
    end
  end

  // Priority encode lowest matching level, lowest insert slot, and occupancy
  always_comb begin
    matchIdx   = {IDX_W{1'b0}};
    insIdx     = {IDX_W{1'b0}};
    anyMatch   = 1'b0;
    anyIns     = 1'b0;
    validCount = {CNT_W{1'b0}};
    for (int i = DEPTH - 1; i >= 0; i--) begin
      matchIdx = cmpMatch[i]  ? IDX_W'(i) : matchIdx;
      insIdx   = cmpBetter[i] ? IDX_W'(i) : insIdx;
      anyMatch = anyMatch | cmpMatch[i];
      anyIns   = anyIns | cmpBetter[i];
    end
    for (int i = 0; i < DEPTH; i++) begin
      validCount = validCount + CNT_W'(cmpValid[i]);
    end
  end

  // Compute the post-update level array and the off-book / miss events
  always_comb begin
    levValidNext  = levValid;
    levPriceNext  = levPrice;
    levSharesNext = levShares;
    offNext       = 1'b0;
    missNext      = 1'b0;
    if ((state == ST_APPLY) && (reqShares != {SHARES_W{1'b0}})) begin
      if (reqOp == BOOK_ADD) begin
        if (anyMatch) begin
          levSharesNext[matchIdx] = satAdd(levShares[matchIdx], reqShares);
        end else if (anyIns) begin
          // open a slot at insIdx; whatever sat in the last slot falls off
          for (int i = 1; i < DEPTH; i++) begin
            if (IDX_W'(i) > insIdx) begin
              levValidNext[i]  = levValid[i-1];
              levPriceNext[i]  = levPrice[i-1];
              levSharesNext[i] = levShares[i-1];
            end else begin
              levValidNext[i]  = levValid[i];
              levPriceNext[i]  = levPrice[i];
              levSharesNext[i] = levShares[i];
            end
          end
          levValidNext[insIdx]  = 1'b1;
          levPriceNext[insIdx]  = reqPrice;
          levSharesNext[insIdx] = reqShares;
          offNext               = levValid[DEPTH-1];
        end else begin
          offNext = 1'b1;
        end
      end else begin
        if (anyMatch) begin
          if (reqShares >= levShares[matchIdx]) begin
            // level emptied: close the gap so valid levels stay contiguous
            for (int i = 0; i < DEPTH - 1; i++) begin
              if (IDX_W'(i) >= matchIdx) begin
                levValidNext[i]  = levValid[i+1];
                levPriceNext[i]  = levPrice[i+1];
                levSharesNext[i] = levShares[i+1];
              end else begin
                levValidNext[i]  = levValid[i];
                levPriceNext[i]  = levPrice[i];
                levSharesNext[i] = levShares[i];
              end
            end
            levValidNext[DEPTH-1]  = 1'b0;
            levPriceNext[DEPTH-1]  = {PRICE_W{1'b0}};
            levSharesNext[DEPTH-1] = {SHARES_W{1'b0}};
          end else begin
            levSharesNext[matchIdx] = levShares[matchIdx] - reqShares;
          end
        end else begin
          missNext = 1'b1;
        end
      end
    end else begin
      offNext  = 1'b0;
      missNext = 1'b0;
    end
  end

  // Level array and pending event flags, written at the end of APPLY
  always_ff @(posedge clkIn) begin
    if (rstIn) begin
      levValid <= {DEPTH{1'b0}};
      for (int i = 0; i < DEPTH; i++) begin
        levPrice[i]  <= {PRICE_W{1'b0}};
        levShares[i] <= {SHARES_W{1'b0}};
      end
      offPend  <= 1'b0;
      missPend <= 1'b0;
    end else begin
      levValid  <= levValidNext;
      levPrice  <= levPriceNext;
      levShares <= levSharesNext;
      offPend   <= offNext;
      missPend  <= missNext;
    end
  end

  // Registered top-of-book view, occupancy and one-cycle event pulses
  always_ff @(posedge clkIn) begin
    if (rstIn) begin
      topLevelOut <= {$bits(bookLevelType){1'b0}};
      topValidOut <= 1'b0;
      levelCntOut <= {CNT_W{1'b0}};
      topChgOut   <= 1'b0;
      offBookOut  <= 1'b0;
      missOut     <= 1'b0;
    end else begin
      topLevelOut.price  <= BOOK_PRICE_W'(levPrice[0]);
      topLevelOut.shares <= BOOK_SHARES_W'(levShares[0]);
      topValidOut        <= levValid[0];
      levelCntOut        <= validCount;
      topChgOut          <= (levValid[0] != topValidOut) ||
                            (BOOK_PRICE_W'(levPrice[0]) != topLevelOut.price) ||
                            (BOOK_SHARES_W'(levShares[0]) != topLevelOut.shares);
      offBookOut         <= offPend;
      missOut            <= missPend;
    end
  end

endmodule

// File: tb/tb_book_side_levels.sv
// Directed bench: a buy book and a sell book (DEPTH=4) driven side by side,
// every expected value written out by hand.
module tb_book_side_levels;
  import book_side_levels_pkg::*;

  logic         clk = 1'b0;
  logic         rst;
  logic         updValid  [2];
  logic         updReady  [2];
  bookOpType    updOp     [2];
  logic [31:0]  updPrice  [2];
  logic [31:0]  updShares [2];
  bookLevelType topLevel  [2];
  logic         topValid  [2];
  logic [2:0]   levelCnt  [2];
  logic         topChg    [2];
  logic         offBook   [2];
  logic         miss      [2];

  int errCnt = 0;
  int chkCnt = 0;
  int accepts;

  always #2 clk = ~clk;

  book_side_levels #(.DEPTH(4), .SIDE(SIDE_BUY)) uBuy (
    .clkIn(clk), .rstIn(rst), .updValidIn(updValid[0]), .updReadyOut(updReady[0]),
    .updOpIn(updOp[0]), .updPriceIn(updPrice[0]), .updSharesIn(updShares[0]),
    .topLevelOut(topLevel[0]), .topValidOut(topValid[0]), .levelCntOut(levelCnt[0]),
    .topChgOut(topChg[0]), .offBookOut(offBook[0]), .missOut(miss[0])
  );

  book_side_levels #(.DEPTH(4), .SIDE(SIDE_SELL)) uSell (
    .clkIn(clk), .rstIn(rst), .updValidIn(updValid[1]), .updReadyOut(updReady[1]),
    .updOpIn(updOp[1]), .updPriceIn(updPrice[1]), .updSharesIn(updShares[1]),
    .topLevelOut(topLevel[1]), .topValidOut(topValid[1]), .levelCntOut(levelCnt[1]),
    .topChgOut(topChg[1]), .offBookOut(offBook[1]), .missOut(miss[1])
  );

  task automatic checkVal(input string tag, input logic [63:0] got, input logic [63:0] exp);
    chkCnt++;
    if (got !== exp) begin
      errCnt++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // One update on book sel, then check the registered outputs two edges after accept
  task automatic upd(input string tag, input int sel, input bookOpType op,
                     input logic [31:0] price, input logic [31:0] shares,
                     input logic [31:0] ePrice, input logic [31:0] eShares,
                     input logic eValid, input logic [2:0] eCnt,
                     input logic eChg, input logic eOff, input logic eMiss);
    int waitCyc = 0;
    @(negedge clk);
    while (updReady[sel] !== 1'b1 && waitCyc < 20) begin
      @(negedge clk);
      waitCyc++;
    end
    if (waitCyc >= 20) checkVal({tag, ".readyTimeout"}, 64'(updReady[sel]), 64'd1);
    updOp[sel]     = op;
    updPrice[sel]  = price;
    updShares[sel] = shares;
    updValid[sel]  = 1'b1;
    @(posedge clk);
    #1 updValid[sel] = 1'b0;
    checkVal({tag, ".readyLow"}, 64'(updReady[sel]), 64'd0);
    @(posedge clk);
    #1 checkVal({tag, ".chgEarly"}, 64'(topChg[sel]), 64'd0);
    @(posedge clk);
    #1;
    checkVal({tag, ".price"},  64'(topLevel[sel].price),  64'(ePrice));
    checkVal({tag, ".shares"}, 64'(topLevel[sel].shares), 64'(eShares));
    checkVal({tag, ".valid"},  64'(topValid[sel]), 64'(eValid));
    checkVal({tag, ".cnt"},    64'(levelCnt[sel]), 64'(eCnt));
    checkVal({tag, ".chg"},    64'(topChg[sel]),   64'(eChg));
    checkVal({tag, ".off"},    64'(offBook[sel]),  64'(eOff));
    checkVal({tag, ".miss"},   64'(miss[sel]),     64'(eMiss));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    for (int s = 0; s < 2; s++) begin
      updValid[s]  = 1'b0;
      updOp[s]     = BOOK_ADD;
      updPrice[s]  = 32'h0;
      updShares[s] = 32'h0;
    end
    repeat (3) @(posedge clk);
    #1;
    checkVal("rst.ready", 64'(updReady[0]), 64'd0);
    checkVal("rst.top",   64'(topLevel[0]), 64'd0);
    checkVal("rst.valid", 64'(topValid[0]), 64'd0);
    checkVal("rst.cnt",   64'(levelCnt[0]), 64'd0);
    @(negedge clk) rst = 1'b0;
    @(posedge clk);
    #1 checkVal("rst.readyUp", 64'(updReady[0]), 64'd1);

    // buy side: insert, merge, fill, off-book
    upd("t1", 0, BOOK_ADD, 32'h22FEFC, 32'h45,  32'h22FEFC, 32'h45,  1'b1, 3'd1, 1'b1, 1'b0, 1'b0);
    @(posedge clk);
    #1 checkVal("t1.chgDrop", 64'(topChg[0]), 64'd0);
    upd("t2",  0, BOOK_ADD, 32'h22FEFC, 32'h555, 32'h22FEFC, 32'h59A, 1'b1, 3'd1, 1'b1, 1'b0, 1'b0);
    upd("t3a", 0, BOOK_ADD, 32'h224000, 32'h554, 32'h22FEFC, 32'h59A, 1'b1, 3'd2, 1'b0, 1'b0, 1'b0);
    upd("t3b", 0, BOOK_ADD, 32'h223000, 32'h553, 32'h22FEFC, 32'h59A, 1'b1, 3'd3, 1'b0, 1'b0, 1'b0);
    upd("t3c", 0, BOOK_ADD, 32'h222000, 32'h552, 32'h22FEFC, 32'h59A, 1'b1, 3'd4, 1'b0, 1'b0, 1'b0);
    upd("t3d", 0, BOOK_ADD, 32'h221000, 32'h551, 32'h22FEFC, 32'h59A, 1'b1, 3'd4, 1'b0, 1'b1, 1'b0);
    // reduce to removal, then a miss
    upd("t4a", 0, BOOK_REDUCE, 32'h22FEFC, 32'h59A, 32'h224000, 32'h554, 1'b1, 3'd3, 1'b1, 1'b0, 1'b0);
    upd("t4b", 0, BOOK_REDUCE, 32'h230000, 32'h1,   32'h224000, 32'h554, 1'b1, 3'd3, 1'b0, 1'b0, 1'b1);
    // insert at top, then mid-book insert pushing the last level out
    upd("t7", 0, BOOK_ADD, 32'h225000, 32'h10, 32'h225000, 32'h10, 1'b1, 3'd4, 1'b1, 1'b0, 1'b0);
    upd("t8", 0, BOOK_ADD, 32'h223800, 32'h7,  32'h225000, 32'h10, 1'b1, 3'd4, 1'b0, 1'b1, 1'b0);
    // walk the book down to confirm ordering 225000,224000,223800,223000
    upd("t9",  0, BOOK_REDUCE, 32'h225000, 32'h10,  32'h224000, 32'h554, 1'b1, 3'd3, 1'b1, 1'b0, 1'b0);
    upd("t10", 0, BOOK_REDUCE, 32'h224000, 32'h554, 32'h223800, 32'h7,   1'b1, 3'd2, 1'b1, 1'b0, 1'b0);
    upd("t11", 0, BOOK_REDUCE, 32'h223800, 32'h3,   32'h223800, 32'h4,   1'b1, 3'd2, 1'b1, 1'b0, 1'b0);
    upd("t12", 0, BOOK_REDUCE, 32'h223800, 32'h100, 32'h223000, 32'h553, 1'b1, 3'd1, 1'b1, 1'b0, 1'b0);
    upd("t13", 0, BOOK_REDUCE, 32'h222000, 32'h1,   32'h223000, 32'h553, 1'b1, 3'd1, 1'b0, 1'b0, 1'b1);
    upd("t14", 0, BOOK_ADD,    32'h223000, 32'h0,   32'h223000, 32'h553, 1'b1, 3'd1, 1'b0, 1'b0, 1'b0);

    // sell side: lower price is better, saturation
    upd("s1", 1, BOOK_ADD,    32'h100, 32'h1, 32'h100, 32'h1, 1'b1, 3'd1, 1'b1, 1'b0, 1'b0);
    upd("s2", 1, BOOK_ADD,    32'h0FF, 32'h2, 32'h0FF, 32'h2, 1'b1, 3'd2, 1'b1, 1'b0, 1'b0);
    upd("s3", 1, BOOK_ADD,    32'h101, 32'h3, 32'h0FF, 32'h2, 1'b1, 3'd3, 1'b0, 1'b0, 1'b0);
    upd("s4", 1, BOOK_REDUCE, 32'h0FF, 32'h2, 32'h100, 32'h1, 1'b1, 3'd2, 1'b1, 1'b0, 1'b0);
    upd("s5", 1, BOOK_ADD, 32'h100, 32'hFFFFFFFF, 32'h100, 32'hFFFFFFFF, 1'b1, 3'd2, 1'b1, 1'b0, 1'b0);
    upd("s6", 1, BOOK_ADD, 32'h100, 32'hFFFFFFFF, 32'h100, 32'hFFFFFFFF, 1'b1, 3'd2, 1'b0, 1'b0, 1'b0);
    upd("s7", 1, BOOK_ADD, 32'h050, 32'h1,        32'h050, 32'h1,        1'b1, 3'd3, 1'b1, 1'b0, 1'b0);

    // back-to-back: valid held high for six cycles
    accepts = 0;
    @(negedge clk);
    updOp[1]     = BOOK_ADD;
    updPrice[1]  = 32'h050;
    updShares[1] = 32'h1;
    updValid[1]  = 1'b1;
    for (int k = 0; k < 6; k++) begin
      checkVal($sformatf("b2b.ready%0d", k), 64'(updReady[1]), (k % 2 == 0) ? 64'd1 : 64'd0);
      if (updReady[1] === 1'b1) accepts++;
      @(negedge clk);
    end
    updValid[1] = 1'b0;
    checkVal("b2b.accepts", 64'(accepts), 64'd3);
    repeat (2) @(posedge clk);
    #1;
    checkVal("b2b.shares", 64'(topLevel[1].shares), 64'd4);
    checkVal("b2b.cnt",    64'(levelCnt[1]), 64'd3);

    // reset arriving during APPLY discards the pending update
    @(negedge clk);
    checkVal("rstApply.readyPre", 64'(updReady[1]), 64'd1);
    updOp[1]     = BOOK_ADD;
    updPrice[1]  = 32'h040;
    updShares[1] = 32'h9;
    updValid[1]  = 1'b1;
    @(posedge clk);
    #1;
    updValid[1] = 1'b0;
    rst         = 1'b1;
    @(posedge clk);
    #1;
    checkVal("rstApply.cnt",    64'(levelCnt[1]), 64'd0);
    checkVal("rstApply.top",    64'(topLevel[1]), 64'd0);
    checkVal("rstApply.valid",  64'(topValid[1]), 64'd0);
    checkVal("rstApply.ready",  64'(updReady[1]), 64'd0);
    checkVal("rstApply.chg",    64'(topChg[1]),   64'd0);
    checkVal("rstApply.buyCnt", 64'(levelCnt[0]), 64'd0);
    @(negedge clk) rst = 1'b0;
    @(posedge clk);
    #1 checkVal("rstApply.readyUp", 64'(updReady[1]), 64'd1);
    repeat (2) @(posedge clk);
    #1;
    checkVal("rstApply.cntAfter", 64'(levelCnt[1]), 64'd0);
    checkVal("rstApply.topAfter", 64'(topLevel[1]), 64'd0);
    checkVal("rstApply.offMiss",  64'({offBook[1], miss[1], topChg[1]}), 64'd0);

    $display("Result: errors=%0d of %0d checks", errCnt, chkCnt);
    $finish;
  end

endmodule
